// File: rtl/ofdm_tx_mapper.sv
// ofdm_tx_mapper: writes one OFDM symbol of pilot/BPSK bins into a BSRAM, one bin per cycle.
// Define OFDM_TX_HERMITIAN_EN to also fill the conjugate-mirrored bins for a real IFFT output.
module ofdm_tx_mapper #(
    parameter int          FFT_LEN = 1024,
    parameter logic [15:0] AMP     = 16'h4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [95:0] data,
    output logic        busy,
    output logic        finish,
    output logic [31:0] din1,
    output logic [10:0] ad1,
    output logic        ce1,
    output logic        wre1
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
    localparam logic [10:0] LAST = 11'(FFT_LEN - 1);
    localparam logic [15:0] NAMP = 16'(0 - int'(AMP));
    state_t      state, nxt;
    logic [10:0] cnt, b;
    logic [95:0] pay;
    logic [6:0]  j;
    logic        pilot, dbin, wr;
    logic [15:0] re;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pay   <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && start) begin
                pay <= data;
                cnt <= '0;
            end else if (state == WRITE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
    always_comb begin
        nxt = (state == IDLE && start)       ? WRITE :
              (state == WRITE && cnt == LAST) ? DONE  :
              (state == DONE)                 ? IDLE  : state;
    end
`ifdef OFDM_TX_HERMITIAN_EN
    logic mir;
    // mirrored bins reuse the value of bin FFT_LEN-cnt; 11-bit wrap makes this exact up to 2048
    assign mir = cnt >= 11'(FFT_LEN - 120) && cnt <= 11'(FFT_LEN - 20);
    assign b   = mir ? 11'(FFT_LEN) - cnt : cnt;
`else
    assign b = cnt;
`endif
    always_comb begin
        pilot = b == 11'd20 || b == 11'd21 || b == 11'd54 || b == 11'd87 || b == 11'd120;
        dbin  = (b >= 11'd22 && b <= 11'd53) || (b >= 11'd55 && b <= 11'd86) ||
                (b >= 11'd88 && b <= 11'd119);
        j     = 7'(b - ((b <= 11'd53) ? 11'd22 : (b <= 11'd86) ? 11'd23 : 11'd24));
        re    = pilot ? AMP : dbin ? (pay[j ^ 7'd7] ? AMP : NAMP) : '0;
        wr    = state == WRITE;
    end
    // every populated bin is purely real, so the conjugate mirror shares the same word
    assign busy   = wr;
    assign finish = state == DONE;
    assign ce1    = wr;
    assign wre1   = wr;
    assign ad1    = wr ? cnt : '0;
    assign din1   = wr ? {re, 16'h0000} : '0;
endmodule

// File: tb/tb_ofdm_tx_mapper.sv
// tb_ofdm_tx_mapper: scoreboard bench for ofdm_tx_mapper; expected bins are queued at start
// and compared against each BSRAM write.
module tb_ofdm_tx_mapper;
    localparam int          FFT_LEN = 1024;
    localparam logic [15:0] AMP     = 16'h4000;
    localparam logic [15:0] NAMP    = 16'hC000;

    logic        clk = 0, rst_n = 0, start = 0;
    logic [95:0] data = '0;
    logic        busy, finish, ce1, wre1;
    logic [31:0] din1;
    logic [10:0] ad1;

    ofdm_tx_mapper #(.FFT_LEN(FFT_LEN), .AMP(AMP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data(data), .busy(busy),
        .finish(finish), .din1(din1), .ad1(ad1), .ce1(ce1), .wre1(wre1)
    );

    always #5 clk = ~clk;

    int          n_asrt = 0, n_fail = 0, cyc = 0, t_start = 0, fin_cnt = 0, f0;
    logic [42:0] q[$];
    logic [31:0] cap[FFT_LEN];
    logic [31:0] exp_mem[FFT_LEN];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference map built from the payload side: payload index j lands on bin 22+j+j/32
    task automatic build(input logic [95:0] d);
        int pil[5] = '{20, 21, 54, 87, 120};
        for (int b = 0; b < FFT_LEN; b++) exp_mem[b] = '0;
        foreach (pil[k]) exp_mem[pil[k]] = {AMP, 16'h0000};
        for (int jj = 0; jj < 96; jj++)
            exp_mem[22 + jj + jj / 32] = {d[jj ^ 7] ? AMP : NAMP, 16'h0000};
`ifdef OFDM_TX_HERMITIAN_EN
        for (int b = 20; b <= 120; b++)
            exp_mem[FFT_LEN - b] = {exp_mem[b][31:16], 16'(-exp_mem[b][15:0])};
`endif
        for (int b = 0; b < FFT_LEN; b++) q.push_back({11'(b), exp_mem[b]});
    endtask

    always @(negedge clk) begin
        logic [42:0] e;
        if (finish) fin_cnt++;
        if (wre1) begin
            chk("ce1_in_write", ce1, 1);
            chk("busy_in_write", busy, 1);
            chk("write_expected", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ad1", ad1, e[42:32]);
                chk("din1", din1, e[31:0]);
                cap[ad1] = din1;
            end
        end
    end

    // call at posedge+#1; start is sampled at the next edge
    task automatic start_symbol(input logic [95:0] d);
        start   = 1;
        data    = d;
        t_start = cyc;
        build(d);
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_finish();
        for (int i = 0; i < FFT_LEN + 20; i++) begin
            @(negedge clk);
            if (finish) break;
        end
        chk("finish_seen", finish, 1);
        chk("latency", cyc - t_start, FFT_LEN + 1);
        chk("busy_in_done", busy, 0);
        chk("ce1_in_done", ce1, 0);
        chk("queue_drained", q.size(), 0);
        @(negedge clk);
        chk("finish_one_cycle", finish, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_finish", finish, 0);
        chk("rst_ce1", ce1, 0);
        chk("rst_wre1", wre1, 0);
        chk("rst_ad1", ad1, 0);
        chk("rst_din1", din1, 0);

        // start on the very first edge after reset release
        rst_n = 1;
        start_symbol({12{8'h55}});
        wait_finish();
        chk("x55_bin22", cap[22], 32'hC0000000);
        chk("x55_bin23", cap[23], 32'h40000000);
        chk("pilot20", cap[20], 32'h40000000);
        chk("pilot21", cap[21], 32'h40000000);
        chk("pilot54", cap[54], 32'h40000000);
        chk("pilot87", cap[87], 32'h40000000);
        chk("pilot120", cap[120], 32'h40000000);

        @(posedge clk); #1;
        start_symbol(96'h0);
        wait_finish();
        for (int jj = 0; jj < 96; jj++) chk("zero_data_bin", cap[22 + jj + jj / 32], 32'hC0000000);
        for (int b = 0; b < 20; b++) chk("low_bins_zero", cap[b], 0);
`ifndef OFDM_TX_HERMITIAN_EN
        for (int b = 121; b < FFT_LEN; b++) chk("high_bins_zero", cap[b], 0);
`endif

        @(posedge clk); #1;
        start_symbol(96'h1);
        wait_finish();
        chk("d1_bin29", cap[29], 32'h40000000);
        chk("d1_bin22", cap[22], 32'hC0000000);
        chk("d1_bin119", cap[119], 32'hC0000000);

        @(posedge clk); #1;
        start_symbol(96'h80);
        wait_finish();
        chk("d80_bin22", cap[22], 32'h40000000);
        chk("d80_bin29", cap[29], 32'hC0000000);
`ifdef OFDM_TX_HERMITIAN_EN
        chk("herm_bin1002", cap[1002], 32'h40000000);
        chk("herm_bin1004", cap[1004], 32'h40000000);
        chk("herm_bin512", cap[512], 0);
        chk("herm_bin0", cap[0], 0);
`endif

        // start re-pulsed mid-symbol with different data must be ignored
        @(posedge clk); #1;
        f0 = fin_cnt;
        start_symbol({12{8'hA3}});
        repeat (100) @(posedge clk);
        #1 start = 1;
        data = {12{8'h1C}};
        @(posedge clk);
        #1 start = 0;
        wait_finish();
        repeat (5) @(negedge clk);
        chk("single_finish", fin_cnt - f0, 1);
        chk("idle_after_done", busy, 0);

        // reset in the middle of the symbol aborts it
        @(posedge clk); #1;
        start_symbol({12{8'h3C}});
        for (int i = 0; i < FFT_LEN; i++) begin
            @(negedge clk);
            if (ad1 == 11'd500) break;
        end
        chk("reached_bin500", ad1, 500);
        #1 rst_n = 0;
        #1;
        chk("abort_ce1", ce1, 0);
        chk("abort_wre1", wre1, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ad1", ad1, 0);
        q.delete();
        f0 = fin_cnt;
        repeat (20) @(negedge clk);
        chk("abort_no_finish", fin_cnt - f0, 0);
        @(posedge clk); #1;
        rst_n = 1;
        start_symbol({12{8'h96}});
        wait_finish();
        repeat (20) @(negedge clk);
        chk("abort_no_extra_finish", fin_cnt - f0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
